// File: rtl/multi_box_overlay.sv
// Multi-box bounding-box overlay for an RGB888 pixel stream.
// Up to NUM_BOXES rectangular borders are drawn from shadow registers that are
// reloaded only at a frame start after a cfg_load request. Two-stage pipeline:
// stage 1 computes the per-box hit vector, stage 2 selects the output colour.
// Optional feature: define OVERLAY_CROSSHAIR_EN to add a centre crosshair per
// box in the inverted box colour, taking priority over every border hit.
module multi_box_overlay #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned NUM_BOXES = 4,
  parameter int unsigned THICKNESS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    h_sync,
  input  logic                    v_sync,
  input  logic [23:0]             pixel_in,
  input  logic [16*NUM_BOXES-1:0] bbox_x_min,
  input  logic [16*NUM_BOXES-1:0] bbox_x_max,
  input  logic [16*NUM_BOXES-1:0] bbox_y_min,
  input  logic [16*NUM_BOXES-1:0] bbox_y_max,
  input  logic [24*NUM_BOXES-1:0] box_color,
  input  logic [NUM_BOXES-1:0]    box_en,
  input  logic                    cfg_load,
  output logic [23:0]             pixel_out,
  output logic                    h_sync_out,
  output logic                    v_sync_out,
  output logic                    cfg_pending,
  output logic                    frame_done
);

  localparam logic [15:0] XLast = 16'(H_ACTIVE - 1);
  localparam logic [15:0] YLast = 16'(V_ACTIVE - 1);
  localparam logic [16:0] Thick = 17'(THICKNESS);

  logic [15:0] x_q, y_q;
  logic        vs_prev_q;

  logic [NUM_BOXES-1:0][15:0] sh_x0_q, sh_x1_q, sh_y0_q, sh_y1_q;
  logic [NUM_BOXES-1:0][23:0] sh_col_q;
  logic [NUM_BOXES-1:0]       sh_en_q;

  logic active, cfg_take, last_pix;

  assign active   = h_sync & v_sync;
  // A load requested in the very cycle of the frame start is honoured too.
  assign cfg_take = v_sync & ~vs_prev_q & (cfg_pending | cfg_load);
  assign last_pix = active && (x_q == XLast) && (y_q == YLast);

  // Inclusive rectangle border test; 17-bit sums avoid any wrap at 0 / FFFF.
  function automatic logic border_hit(input logic [15:0] px, py, x0, x1, y0, y1);
    logic [16:0] ex, ey;
    ex = {1'b0, px};
    ey = {1'b0, py};
    border_hit = (x0 <= x1) && (y0 <= y1) &&
                 (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1) &&
                 ((ex < {1'b0, x0} + Thick) || (ex + Thick > {1'b0, x1}) ||
                  (ey < {1'b0, y0} + Thick) || (ey + Thick > {1'b0, y1}));
  endfunction

`ifdef OVERLAY_CROSSHAIR_EN
  function automatic logic near3(input logic [16:0] a, input logic [16:0] c);
    near3 = (a + 17'd3 >= c) && (a <= c + 17'd3);
  endfunction

  function automatic logic cross_hit(input logic [15:0] px, py, x0, x1, y0, y1);
    logic [16:0] cx, cy;
    cx = ({1'b0, x0} + {1'b0, x1}) >> 1;
    cy = ({1'b0, y0} + {1'b0, y1}) >> 1;
    cross_hit = (x0 <= x1) && (y0 <= y1) &&
                ((({1'b0, py} == cy) && near3({1'b0, px}, cx)) ||
                 (({1'b0, px} == cx) && near3({1'b0, py}, cy)));
  endfunction
`endif

  // Pixel position counters: advance on active pixels, clear outside the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (!v_sync) begin
      x_q <= '0;
      y_q <= '0;
    end else if (h_sync) begin
      if (x_q == XLast) begin
        x_q <= '0;
        y_q <= (y_q == YLast) ? '0 : y_q + 16'd1;
      end else begin
        x_q <= x_q + 16'd1;
      end
    end
  end

  // Shadow box set and pending-load flag; shadows change only at a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q   <= 1'b0;
      cfg_pending <= 1'b0;
      sh_x0_q     <= '0;
      sh_x1_q     <= '0;
      sh_y0_q     <= '0;
      sh_y1_q     <= '0;
      sh_col_q    <= '0;
      sh_en_q     <= '0;
    end else begin
      vs_prev_q <= v_sync;
      if (cfg_take) begin
        sh_x0_q     <= bbox_x_min;
        sh_x1_q     <= bbox_x_max;
        sh_y0_q     <= bbox_y_min;
        sh_y1_q     <= bbox_y_max;
        sh_col_q    <= box_color;
        sh_en_q     <= box_en;
        cfg_pending <= 1'b0;
      end else if (cfg_load) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  logic [NUM_BOXES-1:0] hit_d, hit_q;
  logic [23:0]          pix_q;
  logic                 hs_q, vs_q, last_q;

  // Per-box border hit for the current input pixel.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < int'(NUM_BOXES); i++) begin
      hit_d[i] = active & sh_en_q[i] &
                 border_hit(x_q, y_q, sh_x0_q[i], sh_x1_q[i], sh_y0_q[i], sh_y1_q[i]);
    end
  end

`ifdef OVERLAY_CROSSHAIR_EN
  logic [NUM_BOXES-1:0] ch_d, ch_q;

  // Per-box crosshair hit for the current input pixel.
  always_comb begin
    ch_d = '0;
    for (int i = 0; i < int'(NUM_BOXES); i++) begin
      ch_d[i] = active & sh_en_q[i] &
                cross_hit(x_q, y_q, sh_x0_q[i], sh_x1_q[i], sh_y0_q[i], sh_y1_q[i]);
    end
  end

  // Stage 1 crosshair hit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_q <= '0;
    else        ch_q <= ch_d;
  end
`endif

  // Stage 1: hit vector plus the delayed pixel and qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      pix_q  <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      pix_q  <= pixel_in;
      hs_q   <= h_sync;
      vs_q   <= v_sync;
      last_q <= last_pix;
    end
  end

  logic [23:0] col_sel;

  // Colour select: scanning downward leaves the lowest-index hit in place.
  always_comb begin
    col_sel = pix_q;
    for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
      if (hit_q[i]) col_sel = sh_col_q[i];
    end
`ifdef OVERLAY_CROSSHAIR_EN
    for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
      if (ch_q[i]) col_sel = ~sh_col_q[i];
    end
`endif
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out  <= '0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pixel_out  <= col_sel;
      h_sync_out <= hs_q;
      v_sync_out <= vs_q;
      frame_done <= last_q;
    end
  end

endmodule

// File: tb/tb_multi_box_overlay.sv
// Bench for multi_box_overlay: two instances (border width 1 and 2) share one
// stimulus stream; a frame-level reference model predicts every output.
module tb_multi_box_overlay;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, h_sync, v_sync, cfg_load;
  logic [23:0]       pixel_in;
  logic [16*NB-1:0]  bx0, bx1, by0, by1;
  logic [24*NB-1:0]  bcol;
  logic [NB-1:0]     ben;

  logic [23:0] a_pix, b_pix;
  logic        a_hs, a_vs, a_pend, a_fd, b_hs, b_vs, b_pend, b_fd;

  multi_box_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_BOXES(NB), .THICKNESS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .pixel_in(pixel_in),
    .bbox_x_min(bx0), .bbox_x_max(bx1), .bbox_y_min(by0), .bbox_y_max(by1),
    .box_color(bcol), .box_en(ben), .cfg_load(cfg_load),
    .pixel_out(a_pix), .h_sync_out(a_hs), .v_sync_out(a_vs),
    .cfg_pending(a_pend), .frame_done(a_fd)
  );

  multi_box_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_BOXES(NB), .THICKNESS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .pixel_in(pixel_in),
    .bbox_x_min(bx0), .bbox_x_max(bx1), .bbox_y_min(by0), .bbox_y_max(by1),
    .box_color(bcol), .box_en(ben), .cfg_load(cfg_load),
    .pixel_out(b_pix), .h_sync_out(b_hs), .v_sync_out(b_vs),
    .cfg_pending(b_pend), .frame_done(b_fd)
  );

  int total = 0;
  int bad   = 0;
  int fd_seen = 0;
  int fd_exp  = 0;

  // Reference model state
  int          mx, my;
  logic        mvs_prev, mpend;
  int          s_x0[NB], s_x1[NB], s_y0[NB], s_y1[NB];
  logic [23:0] s_col[NB];
  logic        s_en[NB];

  typedef struct {
    logic [23:0] pa, pb, pin;
    logic        hs, vs, fd, act;
    int          x, y;
  } exp_t;
  exp_t q[$];

  logic [23:0] cap_a[V][H];
  logic [23:0] cap_b[V][H];
  logic [23:0] cap_pin[V][H];

  localparam logic [23:0] Red   = 24'hFF0000;
  localparam logic [23:0] Green = 24'h00FF00;
  localparam logic [23:0] Blue  = 24'h0000FF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Border rule in plain integer arithmetic: lowest enabled, valid box wins.
  function automatic logic [23:0] ref_pix(int t, int x, int y, logic [23:0] pin);
    for (int i = 0; i < NB; i++) begin
      if (s_en[i] && s_x0[i] <= s_x1[i] && s_y0[i] <= s_y1[i] &&
          x >= s_x0[i] && x <= s_x1[i] && y >= s_y0[i] && y <= s_y1[i] &&
          (x < s_x0[i] + t || x > s_x1[i] - t || y < s_y0[i] + t || y > s_y1[i] - t))
        return s_col[i];
    end
    return pin;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.pa = '0; e.pb = '0; e.pin = '0;
    e.hs = 1'b0; e.vs = 1'b0; e.fd = 1'b0; e.act = 1'b0;
    e.x = 0; e.y = 0;
    return e;
  endfunction

  task automatic set_box(input int i, input logic [15:0] x0, x1, y0, y1,
                         input logic [23:0] col, input logic en);
    bx0[16*i +: 16] = x0;
    bx1[16*i +: 16] = x1;
    by0[16*i +: 16] = y0;
    by1[16*i +: 16] = y1;
    bcol[24*i +: 24] = col;
    ben[i] = en;
  endtask

  // One clock: apply inputs, predict, then check the pixel applied one call earlier.
  task automatic cycle(input logic hs, input logic vs, input logic cfg, input logic [23:0] pin);
    exp_t e, o;
    logic act;
    h_sync = hs; v_sync = vs; cfg_load = cfg; pixel_in = pin;
    act = hs && vs;
    e.hs = hs; e.vs = vs; e.act = act; e.x = mx; e.y = my; e.pin = pin;
    e.fd = act && mx == H - 1 && my == V - 1;
    e.pa = act ? ref_pix(1, mx, my, pin) : pin;
    e.pb = act ? ref_pix(2, mx, my, pin) : pin;
    q.push_back(e);
    if (cfg) mpend = 1'b1;
    if (vs && !mvs_prev && mpend) begin
      for (int i = 0; i < NB; i++) begin
        s_x0[i] = int'(bx0[16*i +: 16]);
        s_x1[i] = int'(bx1[16*i +: 16]);
        s_y0[i] = int'(by0[16*i +: 16]);
        s_y1[i] = int'(by1[16*i +: 16]);
        s_col[i] = bcol[24*i +: 24];
        s_en[i] = ben[i];
      end
      mpend = 1'b0;
    end
    if (!vs) begin
      mx = 0; my = 0;
    end else if (act) begin
      if (mx == H - 1) begin
        mx = 0;
        my = (my == V - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    mvs_prev = vs;
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("pix_t1", 32'(a_pix), 32'(o.pa));
    chk("pix_t2", 32'(b_pix), 32'(o.pb));
    chk("hs_out", 32'(a_hs), 32'(o.hs));
    chk("vs_out", 32'(b_vs), 32'(o.vs));
    chk("frame_done_t1", 32'(a_fd), 32'(o.fd));
    chk("frame_done_t2", 32'(b_fd), 32'(o.fd));
    chk("cfg_pending", 32'(a_pend), 32'(mpend));
    chk("cfg_pending_t2", 32'(b_pend), 32'(mpend));
    if (a_fd === 1'b1) fd_seen++;
    if (o.act) begin
      cap_a[o.y][o.x] = a_pix;
      cap_b[o.y][o.x] = b_pix;
      cap_pin[o.y][o.x] = o.pin;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pix"}, 32'(a_pix | b_pix), 32'd0);
    chk({tag, "_sync"}, 32'({a_hs, a_vs, b_hs, b_vs}), 32'd0);
    chk({tag, "_pend"}, 32'({a_pend, b_pend}), 32'd0);
    chk({tag, "_fd"}, 32'({a_fd, b_fd}), 32'd0);
  endtask

  task automatic do_reset();
    h_sync = 1'b0; v_sync = 1'b0; cfg_load = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    mx = 0; my = 0; mpend = 1'b0; mvs_prev = 1'b0;
    for (int i = 0; i < NB; i++) s_en[i] = 1'b0;
    q.delete();
    q.push_back(zero_exp());
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("rst_hold");
    rst_n = 1'b1;
  endtask

  // Blanking, a frame start with h_sync low, then V lines of H active pixels.
  task automatic run_frame(input logic pre_cfg, input int mid_cfg, input int rst_line);
    cycle(1'b0, 1'b0, pre_cfg, 24'($urandom));
    cycle(1'b0, 1'b0, 1'b0, 24'($urandom));
    cycle(1'b0, 1'b1, 1'b0, 24'($urandom));
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y == rst_line && x == 0) begin
          do_reset();
          return;
        end
        if ($urandom_range(7) == 0) cycle(1'b0, 1'b1, 1'b0, 24'($urandom));
        cycle(1'b1, 1'b1, (y * H + x == mid_cfg), 24'($urandom));
      end
      cycle(1'b0, 1'b1, 1'b0, 24'($urandom));
    end
    fd_exp++;
  endtask

  initial begin
    rst_n = 1'b0;
    h_sync = 1'b0; v_sync = 1'b0; cfg_load = 1'b0; pixel_in = '0;
    bx0 = '0; bx1 = '0; by0 = '0; by1 = '0; bcol = '0; ben = '0;
    mx = 0; my = 0; mpend = 1'b0; mvs_prev = 1'b0;
    for (int i = 0; i < NB; i++) begin
      s_x0[i] = 0; s_x1[i] = 0; s_y0[i] = 0; s_y1[i] = 0; s_col[i] = '0; s_en[i] = 1'b0;
    end
    q.push_back(zero_exp());
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Single thin box, loaded before the frame
    set_box(0, 16'd2, 16'd5, 16'd1, 16'd4, Red, 1'b1);
    set_box(1, 16'd0, 16'd0, 16'd0, 16'd0, Green, 1'b0);
    run_frame(1'b1, -1, -1);
    chk("t1_px_2_2", 32'(cap_a[2][2]), 32'(Red));
    chk("t1_px_3_2", 32'(cap_a[2][3]), 32'(cap_pin[2][3]));

    // Two-pixel border
    set_box(0, 16'd2, 16'd9, 16'd1, 16'd6, Red, 1'b1);
    run_frame(1'b1, -1, -1);
    chk("t2_px_3_3", 32'(cap_b[3][3]), 32'(Red));
    chk("t2_px_8_4", 32'(cap_b[4][8]), 32'(Red));
    chk("t2_px_4_3", 32'(cap_b[3][4]), 32'(cap_pin[3][4]));

    // Shared edge priority
    set_box(0, 16'd2, 16'd5, 16'd1, 16'd4, Red, 1'b1);
    set_box(1, 16'd5, 16'd9, 16'd1, 16'd6, Green, 1'b1);
    run_frame(1'b1, -1, -1);
    chk("edge_low_wins", 32'(cap_a[2][5]), 32'(Red));
    set_box(0, 16'd2, 16'd5, 16'd1, 16'd4, Red, 1'b0);
    run_frame(1'b1, -1, -1);
    chk("edge_box1", 32'(cap_a[2][5]), 32'(Green));

    // Mid-frame load takes effect only at the next frame start
    set_box(0, 16'd2, 16'd5, 16'd1, 16'd4, Red, 1'b1);
    set_box(1, 16'd0, 16'd0, 16'd0, 16'd0, Green, 1'b0);
    run_frame(1'b1, -1, -1);
    set_box(0, 16'd8, 16'd12, 16'd2, 16'd6, Blue, 1'b1);
    run_frame(1'b0, 3 * H + 4, -1);
    chk("mid_old_box", 32'(cap_a[2][2]), 32'(Red));
    chk("mid_pending", 32'(a_pend), 32'd1);
    run_frame(1'b0, -1, -1);
    chk("mid_new_box", 32'(cap_a[2][8]), 32'(Blue));
    chk("mid_old_gone", 32'(cap_a[2][2]), 32'(cap_pin[2][2]));
    chk("mid_pend_clr", 32'(a_pend), 32'd0);

    // Inverted box and a box spanning the full coordinate range
    set_box(0, 16'd10, 16'd4, 16'd1, 16'd4, Red, 1'b1);
    set_box(1, 16'd0, 16'hFFFF, 16'd0, 16'd7, Blue, 1'b1);
    run_frame(1'b1, -1, -1);
    chk("inv_box", 32'(cap_a[3][10]), 32'(cap_pin[3][10]));
    chk("wide_no_wrap", 32'(cap_a[3][15]), 32'(cap_pin[3][15]));
    chk("wide_left", 32'(cap_a[3][0]), 32'(Blue));
    chk("wide_top", 32'(cap_a[0][5]), 32'(Blue));

    // Randomized box sets, loads at random points
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NB; i++) begin
        set_box(i, 16'($urandom_range(0, 17)), 16'($urandom_range(0, 17)),
                16'($urandom_range(0, 9)), 16'($urandom_range(0, 9)),
                24'($urandom), 1'($urandom));
      end
      run_frame(1'($urandom), ($urandom_range(1) == 1) ? int'($urandom_range(0, H * V - 1)) : -1,
                -1);
    end

    // Reset mid-frame, then a clean frame must pass through untouched
    set_box(0, 16'd0, 16'd15, 16'd0, 16'd7, Red, 1'b1);
    run_frame(1'b1, -1, -1);
    run_frame(1'b0, -1, 3);
    run_frame(1'b0, -1, -1);
    chk("post_rst_pass", 32'(cap_a[0][0]), 32'(cap_pin[0][0]));
    run_frame(1'b1, -1, -1);
    chk("post_rst_load", 32'(cap_a[0][0]), 32'(Red));
    cycle(1'b0, 1'b0, 1'b0, 24'd0);
    chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_box_overlay.md
MULTI_BOX_OVERLAY -- requirements
Module: multi_box_overlay

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter NUM_BOXES, default 4, legal 1..8: number of boxes drawn.
REQ-004 Parameter THICKNESS, default 2, legal 1..4: border width in pixels, drawn inward from the box edges.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 h_sync, v_sync  in  1 each  active-high video-active qualifiers; a pixel is active when both are 1.
REQ-008 pixel_in  in  24  RGB888 input pixel.
REQ-009 bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max  in  16*NUM_BOXES each  packed box coordinates; box i occupies bits [16i+15:16i].
REQ-010 box_color  in  24*NUM_BOXES  per-box RGB888 colour.
REQ-011 box_en  in  NUM_BOXES  per-box draw enable.
REQ-012 cfg_load  in  1  one-cycle strobe requesting a box-set update.
REQ-013 pixel_out  out  24; h_sync_out, v_sync_out  out  1 each: overlaid pixel and delayed qualifiers.
REQ-014 cfg_pending  out  1  high while a requested update awaits the next frame start.
REQ-015 frame_done  out  1  one-cycle pulse aligned with the output of the last active pixel (x=H_ACTIVE-1, y=V_ACTIVE-1).

Function
REQ-016 Counters x, y (16 bit): on an active pixel, x increments; at x=H_ACTIVE-1, x wraps to 0 and y increments; at y=V_ACTIVE-1 with x wrap, y wraps to 0; v_sync=0 clears both; h_sync=0 with v_sync=1 holds both.
REQ-017 Box geometry, colours and enables are drawn from shadow registers, never directly from the inputs.
REQ-018 cfg_load=1 sets cfg_pending; on a v_sync 0->1 transition with cfg_pending=1 (including cfg_load asserted in that same cycle), all inputs from REQ-009..011 are captured into the shadows and cfg_pending clears.
REQ-019 cfg_load during an active frame does not change drawing until the next v_sync rising edge; a repeated cfg_load while pending has no additional effect.
REQ-020 Box i is a hit when shadow enable i=1, x_min<=x_max, y_min<=y_max, the pixel lies inside the inclusive rectangle, and (x<x_min+THICKNESS or x>x_max-THICKNESS or y<y_min+THICKNESS or y>y_max-THICKNESS).
REQ-021 Edge arithmetic uses 17-bit values so that x_min+THICKNESS never overflows and x_max-THICKNESS never underflows; a box narrower than 2*THICKNESS is fully filled.
REQ-022 On overlapping hits, the lowest-index box colour wins.
REQ-023 Non-active pixels and non-hit pixels pass pixel_in unchanged.
REQ-024 Latency is exactly 2 cycles: pixel_out, h_sync_out and v_sync_out correspond to the inputs of two cycles earlier, with one stage computing the hit vector and one selecting the colour.
REQ-025 Throughput is one pixel per cycle, with no stall path.

Reset
REQ-026 While rst_n=0: pixel_out=0, h_sync_out=0, v_sync_out=0, cfg_pending=0, frame_done=0, x=y=0, all shadow enables=0, and pipeline registers=0.
REQ-027 Reset asserted mid-frame aborts the frame; after release, no box is drawn until a cfg_load followed by a v_sync rising edge.

Configuration
REQ-028 Macro OVERLAY_CROSSHAIR_EN defined: additionally draws, for each enabled valid box, a crosshair at cx=(x_min+x_max)>>1, cy=(y_min+y_max)>>1 (17-bit sum), covering pixels with (y=cy and |x-cx|<=3) or (x=cx and |y-cy|<=3), in colour ~box_color; crosshair hits take priority over all border hits, and latency is unchanged.
REQ-029 Macro undefined: no crosshair logic is present, and behaviour is exactly REQ-016..027.

Verification
REQ-030 H_ACTIVE=16, V_ACTIVE=8, THICKNESS=1, box0=(2,5,1,4), red, enabled, cfg_load before the frame: pixel (2,2) out=FF0000; pixel (3,2) out=pixel_in; output appears 2 cycles after input.
REQ-031 THICKNESS=2, box0=(2,9,1,6): pixels (3,3) and (8,4) are red; (4,3) passes through.
REQ-032 box0 red and box1 green (00FF00) sharing edge x=5: pixel on x=5 is red; with box0 disabled, it is green.
REQ-033 cfg_load mid-frame with a new box0: current frame is unchanged, cfg_pending=1; after the v_sync rise, the new box is drawn and cfg_pending=0.
REQ-034 box0 x_min=10 > x_max=4: no pixel modified; box at x_min=0, x_max=FFFF: no wrap artefacts.
REQ-035 rst_n pulsed low at frame line 3: outputs are 0 immediately; next frame passes pixel_in unmodified; frame_done pulses once per completed frame.
